// File: rtl/sim_top.sv
// Synthetic core stand-in for the difftest harness.
// Retires a fixed LFSR-driven instruction stream, then polls the UART input once and prints an
// optional echo byte followed by "HIT GOOD TRAP\n". A perf dump prints "Pxxxx\n" (hex cycle count).
//
// Ports:
//   clock, reset                 clock; synchronous active-low reset
//   io_logCtrl_log_*             log controls (accepted, no effect)
//   io_perfInfo_clean            zero the perf cycle counter
//   io_perfInfo_dump             request a perf counter dump over the UART
//   io_uart_out_valid/_ch        UART output byte strobe and data
//   io_uart_in_valid             one-cycle input poll strobe
//   io_uart_in_ch                UART input byte, 0xFF = nothing
//   difftest_step                instructions retired this cycle
module sim_top #(
  parameter int unsigned STEP_WIDTH   = 8,
  parameter int unsigned COMMIT_WIDTH = 6,
  parameter int unsigned TOTAL_INSTR  = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [63:0]           io_logCtrl_log_begin,
  input  logic [63:0]           io_logCtrl_log_end,
  input  logic [63:0]           io_logCtrl_log_level,
  input  logic                  io_perfInfo_clean,
  input  logic                  io_perfInfo_dump,
  output logic                  io_uart_out_valid,
  output logic [7:0]            io_uart_out_ch,
  output logic                  io_uart_in_valid,
  input  logic [7:0]            io_uart_in_ch,
  output logic [STEP_WIDTH-1:0] difftest_step
);

  localparam int unsigned CntW = $clog2(TOTAL_INSTR + 1);

  typedef enum logic [1:0] {StRun, StPoll, StMsg, StDone} state_e;

  state_e                state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [CntW-1:0]       retired_q, retired_d;
  logic [63:0]           perf_cyc_q, perf_cyc_d;
  logic                  dump_act_q, dump_act_d;
  logic [2:0]            dump_idx_q, dump_idx_d;
  logic [15:0]           dump_val_q, dump_val_d;
  logic [3:0]            msg_idx_q, msg_idx_d;
  logic                  echo_pend_q, echo_pend_d;
  logic [7:0]            echo_q, echo_d;
  logic                  poll_q, poll_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            out_ch_q, out_ch_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;

  logic [31:0] rem, k;
  logic        lfsr_fb;
  logic        echo_now;
  logic [7:0]  echo_ch_now;

  logic unused_log;
  assign unused_log = ^{io_logCtrl_log_begin, io_logCtrl_log_end, io_logCtrl_log_level};

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  function automatic logic [7:0] msg_char(input logic [3:0] i);
    logic [7:0] c;
    case (i)
      4'd0:    c = 8'h48; // H
      4'd1:    c = 8'h49; // I
      4'd2:    c = 8'h54; // T
      4'd3:    c = 8'h20;
      4'd4:    c = 8'h47; // G
      4'd5:    c = 8'h4F; // O
      4'd6:    c = 8'h4F; // O
      4'd7:    c = 8'h44; // D
      4'd8:    c = 8'h20;
      4'd9:    c = 8'h54; // T
      4'd10:   c = 8'h52; // R
      4'd11:   c = 8'h41; // A
      4'd12:   c = 8'h50; // P
      default: c = 8'h0A;
    endcase
    return c;
  endfunction

  // Retire count: min(lfsr[2:0], COMMIT_WIDTH, remaining)
  always_comb begin
    rem = TOTAL_INSTR - 32'(retired_q);
    k   = {29'd0, lfsr_q[2:0]};
    if (k > COMMIT_WIDTH) k = COMMIT_WIDTH;
    if (k > rem)          k = rem;
  end

  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // The poll byte is consumed on the edge right after the strobe; if the dump owns the UART then,
  // it is parked in echo_q until the dump finishes.
  always_comb begin
    if (poll_q) begin
      echo_now    = (io_uart_in_ch != 8'hFF);
      echo_ch_now = io_uart_in_ch;
    end else begin
      echo_now    = echo_pend_q;
      echo_ch_now = echo_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    retired_d   = retired_q;
    perf_cyc_d  = perf_cyc_q;
    dump_act_d  = dump_act_q;
    dump_idx_d  = dump_idx_q;
    dump_val_d  = dump_val_q;
    msg_idx_d   = msg_idx_q;
    echo_pend_d = echo_pend_q;
    echo_d      = echo_q;
    poll_d      = 1'b0;
    out_valid_d = 1'b0;
    out_ch_d    = 8'h00;
    step_d      = '0;

    if (state_q != StDone) perf_cyc_d = perf_cyc_q + 64'd1;
    if (io_perfInfo_clean) perf_cyc_d = '0;

    // Dump engine; it has UART priority over the message.
    if (state_q == StDone) begin
      dump_act_d = 1'b0;
    end else if (dump_act_q) begin
      out_valid_d = 1'b1;
      case (dump_idx_q)
        3'd0:    out_ch_d = 8'h50; // P
        3'd1:    out_ch_d = hex_char(dump_val_q[15:12]);
        3'd2:    out_ch_d = hex_char(dump_val_q[11:8]);
        3'd3:    out_ch_d = hex_char(dump_val_q[7:4]);
        3'd4:    out_ch_d = hex_char(dump_val_q[3:0]);
        default: out_ch_d = 8'h0A;
      endcase
      dump_idx_d = dump_idx_q + 3'd1;
      if (dump_idx_q == 3'd5) dump_act_d = 1'b0;
    end else if (io_perfInfo_dump) begin
      dump_act_d = 1'b1;
      dump_idx_d = 3'd0;
      dump_val_d = perf_cyc_q[15:0];
    end

    unique case (state_q)
      StRun: begin
        step_d    = STEP_WIDTH'(k);
        retired_d = retired_q + CntW'(k);
        lfsr_d    = {lfsr_fb, lfsr_q[15:1]};
        if (32'(retired_q) + k == TOTAL_INSTR) state_d = StPoll;
      end
      StPoll: begin
        poll_d      = 1'b1;
        msg_idx_d   = 4'd0;
        echo_pend_d = 1'b0;
        state_d     = StMsg;
      end
      StMsg: begin
        if (dump_act_q) begin
          echo_pend_d = echo_now;
          echo_d      = echo_ch_now;
        end else if (echo_now) begin
          out_valid_d = 1'b1;
          out_ch_d    = echo_ch_now;
          echo_pend_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
          out_ch_d    = msg_char(msg_idx_q);
          msg_idx_d   = msg_idx_q + 4'd1;
          if (msg_idx_q == 4'd13) state_d = StDone;
        end
      end
      StDone: ;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StRun;
      lfsr_q      <= 16'hACE1;
      retired_q   <= '0;
      perf_cyc_q  <= '0;
      dump_act_q  <= 1'b0;
      dump_idx_q  <= 3'd0;
      dump_val_q  <= 16'd0;
      msg_idx_q   <= 4'd0;
      echo_pend_q <= 1'b0;
      echo_q      <= 8'h00;
      poll_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= 8'h00;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      retired_q   <= retired_d;
      perf_cyc_q  <= perf_cyc_d;
      dump_act_q  <= dump_act_d;
      dump_idx_q  <= dump_idx_d;
      dump_val_q  <= dump_val_d;
      msg_idx_q   <= msg_idx_d;
      echo_pend_q <= echo_pend_d;
      echo_q      <= echo_d;
      poll_q      <= poll_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      step_q      <= step_d;
    end
  end

  assign io_uart_out_valid = out_valid_q;
  assign io_uart_out_ch    = out_ch_q;
  assign io_uart_in_valid  = poll_q;
  assign difftest_step     = step_q;

endmodule

// File: tb/tb_sim_top.sv
// Directed, table-driven bench for sim_top: reset hold, retirement sequence, poll/message,
// echo, perf dump (with overlap and simultaneous clean), dump in DONE, reset mid-message.
module tb_sim_top;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_perfInfo_clean;
  logic        io_perfInfo_dump;
  logic        io_uart_out_valid;
  logic [7:0]  io_uart_out_ch;
  logic        io_uart_in_valid;
  logic [7:0]  io_uart_in_ch;
  logic [7:0]  difftest_step;
  logic [63:0] log_begin = 64'h0000_0000_0000_0010;
  logic [63:0] log_end   = 64'hFFFF_0000_1234_5678;
  logic [63:0] log_level = 64'h3;

  always #5 clock = ~clock;

  sim_top #(
    .STEP_WIDTH  (8),
    .COMMIT_WIDTH(6),
    .TOTAL_INSTR (64)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .io_logCtrl_log_begin(log_begin),
    .io_logCtrl_log_end  (log_end),
    .io_logCtrl_log_level(log_level),
    .io_perfInfo_clean   (io_perfInfo_clean),
    .io_perfInfo_dump    (io_perfInfo_dump),
    .io_uart_out_valid   (io_uart_out_valid),
    .io_uart_out_ch      (io_uart_out_ch),
    .io_uart_in_valid    (io_uart_in_valid),
    .io_uart_in_ch       (io_uart_in_ch),
    .difftest_step       (difftest_step)
  );

  typedef struct {
    logic       rst_n;
    logic       clean;
    logic       dump;
    logic [7:0] in_ch;
    logic [7:0] step;
    logic       in_v;
    logic       out_v;
    logic [7:0] ch;
  } vec_t;

  typedef struct {
    logic [7:0]  in_ch;
    int          clean_at;
    int          dump_at;
    int          dump2_at;
    logic [47:0] dump_bytes;
    bit          has_dump;
    int          msg_start;
    bit          echo;
  } scen_t;

  int          checks = 0;
  int          failures = 0;
  int          step_sum;
  int          step_max;
  vec_t        vq[$];
  logic [7:0]  exp_steps [23];
  logic [111:0] msg_bits;
  scen_t       sc [5];

  function automatic vec_t mk(input logic rst_n, input logic clean, input logic dump,
                              input logic [7:0] in_ch, input logic [7:0] step,
                              input logic in_v, input logic out_v, input logic [7:0] ch);
    vec_t v;
    v.rst_n = rst_n; v.clean = clean; v.dump = dump; v.in_ch = in_ch;
    v.step = step; v.in_v = in_v; v.out_v = out_v; v.ch = ch;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name, input int cyc);
    reset             = v.rst_n;
    io_perfInfo_clean = v.clean;
    io_perfInfo_dump  = v.dump;
    io_uart_in_ch     = v.in_ch;
    @(posedge clock);
    #1;
    checks++;
    if ({difftest_step, io_uart_in_valid, io_uart_out_valid, io_uart_out_ch} !==
        {v.step, v.in_v, v.out_v, v.ch}) begin
      failures++;
      $display("FAIL %s cycle %0d: got step=%0d in_valid=%b out_valid=%b ch=%02h, want step=%0d in_valid=%b out_valid=%b ch=%02h",
               name, cyc, difftest_step, io_uart_in_valid, io_uart_out_valid, io_uart_out_ch,
               v.step, v.in_v, v.out_v, v.ch);
    end
    step_sum += int'(difftest_step);
    if (int'(difftest_step) > step_max) step_max = int'(difftest_step);
  endtask

  task automatic reset_hold(input string name);
    for (int i = 0; i < 10; i++) begin
      apply(mk(1'b0, i[0], ~i[0], 8'h41, 8'd0, 1'b0, 1'b0, 8'h00), name, i + 1);
    end
  endtask

  // Cycle n: inputs sampled on edge n after reset release, outputs checked just after edge n.
  task automatic build(input scen_t s, input int ncyc);
    for (int n = 1; n <= ncyc; n++) begin
      vec_t v;
      int   m;
      int   j;
      v.rst_n = 1'b1;
      v.clean = (n == s.clean_at);
      v.dump  = (n == s.dump_at) || (n == s.dump2_at);
      v.in_ch = s.in_ch;
      v.step  = 8'd0;
      if (n <= 23) v.step = exp_steps[n-1];
      v.in_v  = (n == 24);
      v.out_v = 1'b0;
      v.ch    = 8'h00;
      if (s.has_dump && n > s.dump_at && n <= s.dump_at + 6) begin
        j       = n - s.dump_at - 1;
        v.out_v = 1'b1;
        v.ch    = 8'(s.dump_bytes >> (8 * (5 - j)));
      end else if (s.echo && n == s.msg_start) begin
        v.out_v = 1'b1;
        v.ch    = s.in_ch;
      end else begin
        m = n - s.msg_start - (s.echo ? 1 : 0);
        if (m >= 0 && m < 14) begin
          v.out_v = 1'b1;
          v.ch    = 8'(msg_bits >> (8 * (13 - m)));
        end
      end
      vq.push_back(v);
    end
  endtask

  task automatic run_vq(input string name);
    foreach (vq[i]) apply(vq[i], name, i + 1);
    vq.delete();
  endtask

  initial begin
    reset = 1'b0; io_perfInfo_clean = 1'b0; io_perfInfo_dump = 1'b0; io_uart_in_ch = 8'hFF;
    step_sum = 0; step_max = 0;
    exp_steps = '{8'd1, 8'd0, 8'd0, 8'd4, 8'd6, 8'd6, 8'd3, 8'd1, 8'd4, 8'd6, 8'd3, 8'd5,
                  8'd2, 8'd5, 8'd2, 8'd5, 8'd2, 8'd1, 8'd0, 8'd4, 8'd2, 8'd1, 8'd1};
    msg_bits = "HIT GOOD TRAP\n";
    //        in_ch  clean dump dump2 bytes     has   msg echo
    sc[0] = '{8'hFF, 0,    0,   50,   48'd0,    1'b0, 25, 1'b0}; // plain; dump in DONE
    sc[1] = '{8'h41, 0,    0,   0,    48'd0,    1'b0, 25, 1'b1}; // echo 'A'
    sc[2] = '{8'hFF, 5,    21,  23,   "P000F\n", 1'b1, 28, 1'b0}; // clean+dump, 2nd ignored
    sc[3] = '{8'h41, 0,    21,  0,    "P0014\n", 1'b1, 28, 1'b1}; // echo parked behind dump
    sc[4] = '{8'hFF, 10,   10,  0,    "P0009\n", 1'b1, 25, 1'b0}; // clean+dump same edge

    reset_hold("reset_hold");

    step_sum = 0; step_max = 0;
    build(sc[0], 55);
    run_vq("plain");
    checks++;
    if (step_sum != 64) begin
      failures++;
      $display("FAIL step_sum: got %0d, want 64", step_sum);
    end
    checks++;
    if (step_max > 6) begin
      failures++;
      $display("FAIL step_max: got %0d, want <= 6", step_max);
    end

    for (int s = 1; s < 5; s++) begin
      reset_hold($sformatf("reset_before_%0d", s));
      build(sc[s], 55);
      run_vq($sformatf("scenario_%0d", s));
    end

    // Reset mid-message: 'O' (byte 5) goes out on cycle 30, reset sampled on 31.
    reset_hold("reset_before_mid");
    build(sc[0], 30);
    for (int i = 0; i < 3; i++) vq.push_back(mk(1'b0, 1'b0, 1'b0, 8'hFF, 8'd0, 1'b0, 1'b0, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'hFF, 8'd1, 1'b0, 1'b0, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'hFF, 8'd0, 1'b0, 1'b0, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'hFF, 8'd0, 1'b0, 1'b0, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'hFF, 8'd4, 1'b0, 1'b0, 8'h00));
    run_vq("reset_mid_msg");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sim_top.md
# sim_top

Self-contained simulation top (DUT `SimTop`) that stands in for a processor core under the difftest harness. It runs a fixed synthetic instruction stream, reports per-cycle retirement counts on `difftest_step`, and prints a perf dump and a final "HIT GOOD TRAP" message over a byte-wide UART. It sits directly under the simulation testbench, which consumes `difftest_step` and the UART byte stream.

## Interface
- `STEP_WIDTH`, 8: width of `difftest_step`.
- `COMMIT_WIDTH`, 6: maximum instructions retired per cycle.
- `TOTAL_INSTR`, 64: total instructions in the synthetic program. Must be ≥1.

- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `io_logCtrl_log_begin`  in  64  log window start cycle. Accepted but has no effect on outputs.
- `io_logCtrl_log_end`  in  64  log window end cycle. Accepted but has no effect on outputs.
- `io_logCtrl_log_level`  in  64  log level. Accepted but has no effect on outputs.
- `io_perfInfo_clean`  in  1  zero the perf cycle counter.
- `io_perfInfo_dump`  in  1  print the perf counter over UART.
- `io_uart_out_valid`  out  1  `io_uart_out_ch` carries a byte this cycle.
- `io_uart_out_ch`  out  8  UART output byte.
- `io_uart_in_valid`  out  1  input poll strobe.
- `io_uart_in_ch`  in  8  input byte. 0xFF means no input.
- `difftest_step`  out  STEP_WIDTH  instructions retired this cycle.

## Operation
- **States:** RUN → POLL → MSG → DONE.
- **Reset.** All outputs registered and 0. `lfsr` = 16'hACE1, `retired` = 0, `perf_cyc` = 0, state = RUN, dump idle.
- **RUN, each cycle.**
  - `k = min(lfsr[2:0], COMMIT_WIDTH, TOTAL_INSTR − retired)`.
  - `difftest_step <= k`; `retired += k`.
  - `lfsr` advances as a Fibonacci LFSR: `fb = l[0]^l[2]^l[3]^l[5]`; `lfsr = {fb, l[15:1]}`.
  - When `retired + k == TOTAL_INSTR`, go to POLL next cycle.
- **Outside RUN.** `difftest_step` = 0.
- **perf_cyc.**
  - 64-bit counter; increments every cycle in RUN, POLL and MSG.
  - `io_perfInfo_clean` makes the next value 0.
- **Dump.**
  - A `io_perfInfo_dump` high cycle with the dump idle snapshots `perf_cyc[15:0]`, using the pre-clean value when clean is asserted in the same cycle.
  - The dump then emits 6 bytes: 'P', four uppercase hex digits (MSB first), '\n'.
  - A dump request while a dump is printing is ignored.
  - Dump requests are honored in RUN, POLL and MSG, but not in DONE.
- **POLL.**
  - Lasts exactly one cycle, during which `io_uart_in_valid` = 1.
  - `io_uart_in_ch` is sampled on that edge.
  - If the sampled byte ≠ 0xFF, it is emitted before the message.
- **MSG.**
  - Emits the optional echo byte, then the 14 bytes "HIT GOOD TRAP\n".
  - Then goes to DONE.
- **UART arbitration.**
  - One byte per cycle, no backpressure.
  - An in-progress dump has priority: MSG bytes stall until the dump's last byte has been emitted.
- **DONE.** All outputs 0 until reset.
- **Reset mid-operation.** Aborts everything, including partial dumps and messages; the sequence restarts from seed.

## Timing
- All outputs are registered.
- First rising edge with `reset` = 1: `difftest_step` = 1 (seed low bits 001), visible after that edge.
- Subsequent steps follow the LFSR sequence 0xACE1, 0x5670, 0xAB38, … giving values 1, 0, 0, ….
- The poll strobe appears in the cycle after the last nonzero step.
- First MSG byte appears one cycle after POLL.
- Dump: first byte one cycle after the request edge; bytes on consecutive cycles.
- `io_uart_out_valid` is high exactly on cycles carrying a byte.

## Test plan
- **Reset hold.** Hold `reset` = 0 for 10 cycles → all outputs 0, `io_uart_in_valid` = 0.
- **Retirement.** Release reset with `TOTAL_INSTR` = 64 → first steps 1, 0, 0; step never exceeds 6. The sum of all steps equals 64 exactly, and the last step is clipped to the remainder.
- **Poll and message.** Drive `io_uart_in_ch` = 0xFF → one poll cycle, then 14 consecutive bytes "HIT GOOD TRAP\n", then all outputs 0 forever.
- **Echo.** Drive `io_uart_in_ch` = 0x41 at poll → the byte stream is 'A' followed by "HIT GOOD TRAP\n".
- **Perf dump.** Pulse `io_perfInfo_clean` at RUN cycle 5, then `io_perfInfo_dump` 16 cycles later → bytes "P000F\n"; a second dump pulse during printing is ignored. The message starts only after the dump's '\n'.
- **Reset mid-message.** Assert reset during MSG → output stops the next cycle; after release the step sequence restarts at 1, 0, 0.
